cd_diff_stream: RTL

Streaming change-detection stage inside the Computer_System video path. It consumes a packed pixel-pair stream holding a reference-image pixel and a current-image pixel. It computes the absolute difference per pixel, compares it against a threshold, and emits an RGB565 overlay: changed pixels in red, others as grayscale of the current image. Its output feeds the VGA pixel buffer. A per-frame changed-pixel count is also reported for the HPS.

---
 rtl/cd_diff_stream.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/cd_diff_stream.sv
// rtl/cd_diff_stream.sv - change-detection overlay stage for the video path
// Marks pixels whose |ref - cur| exceeds a per-frame threshold in red, otherwise passes gray.
module cd_diff_stream #(
  parameter int PIX_W        = 8,
  parameter int FRAME_PIXELS = 76800,
  parameter int CNT_W        = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PIX_W-1:0]   threshold,
  input  logic [2*PIX_W-1:0] in_data,
  input  logic               in_valid,
  input  logic               in_sop,
  input  logic               in_eop,
  output logic               in_ready,
  output logic [15:0]        out_data,
  output logic               out_valid,
  output logic               out_sop,
  output logic               out_eop,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   count,
  output logic               count_valid,
  output logic               frame_err
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, FRAME} state_t;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   thr_q, thr_d;
  logic               en_q, en_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               s1_valid_q, s1_valid_d;
  logic [PIX_W-1:0]   s1_diff_q, s1_diff_d;
  logic [5:0]         s1_cur_q, s1_cur_d;
  logic               s1_sop_q, s1_sop_d;
  logic               s1_eop_q, s1_eop_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        out_data_q, out_data_d;
  logic               out_sop_q, out_sop_d;
  logic               out_eop_q, out_eop_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               count_valid_q, count_valid_d;
  logic               frame_err_q, frame_err_d;

  logic               s2_adv, s1_adv, accept, in_frame, at_last, changed;
  logic [PIX_W-1:0]   ref_pix, cur_pix, diff_abs;
  logic [PIX_W:0]     diff_wide;
  logic [CNT_W-1:0]   beat_idx;
  logic [15:0]        gray;

  always_comb begin
    s2_adv    = !out_valid_q || out_ready;
    s1_adv    = !s1_valid_q || s2_adv;
    accept    = in_valid && s1_adv;
    ref_pix   = in_data[2*PIX_W-1:PIX_W];
    cur_pix   = in_data[PIX_W-1:0];
    diff_wide = {1'b0, ref_pix} - {1'b0, cur_pix};
    diff_abs  = diff_wide[PIX_W] ? PIX_W'(-diff_wide) : diff_wide[PIX_W-1:0];
    in_frame  = in_sop || (state_q == FRAME);
    beat_idx  = in_sop ? '0 : idx_q + CNT_W'(1);
    at_last   = (beat_idx == LAST_IDX);
    // S1 beats always belong to the frame whose settings are currently latched
    changed   = en_q && (s1_diff_q > thr_q);
    gray      = {s1_cur_q[5:1], s1_cur_q, s1_cur_q[5:1]};

    state_d       = state_q;
    thr_d         = thr_q;
    en_d          = en_q;
    idx_d         = idx_q;
    s1_valid_d    = s1_valid_q;
    s1_diff_d     = s1_diff_q;
    s1_cur_d      = s1_cur_q;
    s1_sop_d      = s1_sop_q;
    s1_eop_d      = s1_eop_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    run_cnt_d     = run_cnt_q;
    count_d       = count_q;
    count_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    if (s1_adv) s1_valid_d = 1'b0;

    if (accept && in_frame) begin
      s1_valid_d = 1'b1;
      s1_diff_d  = diff_abs;
      s1_cur_d   = cur_pix[PIX_W-1 -: 6];
      s1_sop_d   = in_sop;
      s1_eop_d   = in_eop || at_last;
      idx_d      = beat_idx;
      state_d    = (in_eop || at_last) ? IDLE : FRAME;
      if (in_sop) begin
        thr_d = threshold;
        en_d  = enable;
      end
      // covers restart mid-frame, early EOP and missing EOP alike
      frame_err_d = (in_sop && (state_q == FRAME)) || (in_eop != at_last);
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
      if (s1_valid_q) begin
        out_data_d = changed ? 16'hF800 : gray;
        out_sop_d  = s1_sop_q;
        out_eop_d  = s1_eop_q;
        if (s1_sop_q)
          run_cnt_d = CNT_W'(changed);
        else if (changed && (run_cnt_q != CNT_MAX))
          run_cnt_d = run_cnt_q + CNT_W'(1);
      end
    end

    // run_cnt_q still holds this frame's total on the edge its EOP leaves
    if (out_valid_q && out_ready && out_eop_q) begin
      count_d       = run_cnt_q;
      count_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      thr_q         <= '0;
      en_q          <= 1'b0;
      idx_q         <= '0;
      s1_valid_q    <= 1'b0;
      s1_diff_q     <= '0;
      s1_cur_q      <= '0;
      s1_sop_q      <= 1'b0;
      s1_eop_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      run_cnt_q     <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      thr_q         <= thr_d;
      en_q          <= en_d;
      idx_q         <= idx_d;
      s1_valid_q    <= s1_valid_d;
      s1_diff_q     <= s1_diff_d;
      s1_cur_q      <= s1_cur_d;
      s1_sop_q      <= s1_sop_d;
      s1_eop_q      <= s1_eop_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      run_cnt_q     <= run_cnt_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign in_ready    = s1_adv;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign count       = count_q;
  assign count_valid = count_valid_q;
  assign frame_err   = frame_err_q;
endmodule
